mem_rr_arbiter: RTL and testbench

//  Shares one single-ported memory slave (e.g. MEM_Dram data side) between two request/response masters.

---
 rtl/mem_rr_arbiter_pkg.sv | 32 +++
 rtl/mem_rr_arbiter_if.sv | 32 +++
 rtl/mem_rr_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_rr_arbiter.sv | 106 ++++++++++
 tb/tb_mem_rr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared types for the two-master memory arbiter: FSM states, request payload, grant helper.
// Widths are fixed here so the interface and every instance agree on the payload layout.
package mem_rr_arbiter_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
  } mem_req_t;

  function automatic logic [1:0] idx_to_onehot(input logic idx, input logic any);
    logic [1:0] oh;
    oh = 2'b00;
    if (any) begin
      oh[idx] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
`timescale 1ns/1ps
// One request/response memory channel; the master modport issues requests, the slave modport answers.
// Used for both master-facing ports and the single slave-facing port of the arbiter.
interface mem_rr_arbiter_if;
  import mem_rr_arbiter_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  mem_req_t              req;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid,
    output req,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick2.sv
`timescale 1ns/1ps
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to the one that did not win last.
// Zero latency; no state, so the caller owns the last-grant register.
module mem_rr_arbiter_rr_pick2
  import mem_rr_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);

  always_comb begin
    idx_o = 1'b0;
    case (valid_i)
      2'b01:   idx_o = 1'b0;
      2'b10:   idx_o = 1'b1;
      2'b11:   idx_o = ~last_i;
      default: idx_o = 1'b0;
    endcase
    gnt_o = idx_to_onehot(idx_o, |valid_i);
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin share of one single-ported memory between two masters; accept at N, slave request at N+1.
// One transaction in flight: slave stalls hold the registered payload, response stalls pass through to the owner.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  mem_rr_arbiter_if.slave  m0,
  mem_rr_arbiter_if.slave  m1,
  mem_rr_arbiter_if.master s
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q,  last_d;
  mem_req_t   req_q,   req_d;

  logic [1:0] req_vld;
  logic [1:0] pick_gnt;
  logic       pick_idx;
  logic [1:0] req_rdy;
  logic [1:0] resp_vld;
  logic       s_req_vld;
  logic       s_resp_rdy;
  logic       owner_resp_rdy;

  assign req_vld = {m1.req_valid, m0.req_valid};

  mem_rr_arbiter_rr_pick2 u_pick (
    .valid_i (req_vld),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    req_d          = req_q;
    req_rdy        = 2'b00;
    resp_vld       = 2'b00;
    s_req_vld      = 1'b0;
    s_resp_rdy     = 1'b0;
    owner_resp_rdy = grant_q ? m1.resp_ready : m0.resp_ready;

    case (state_q)
      ARB_IDLE: begin
        // Gate with rstn so no ready pulse escapes while reset is held.
        if (rstn && (|req_vld)) begin
          req_rdy = pick_gnt;
          grant_d = pick_idx;
          req_d   = pick_idx ? m1.req : m0.req;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        s_req_vld = 1'b1;
        if (s.req_ready) begin
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        s_resp_rdy        = owner_resp_rdy;
        resp_vld[grant_q] = s.resp_valid;
        if (s.resp_valid && owner_resp_rdy) begin
          last_d  = grant_q;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
    end
  end

  assign m0.req_ready  = req_rdy[0];
  assign m1.req_ready  = req_rdy[1];
  assign m0.resp_valid = resp_vld[0];
  assign m1.resp_valid = resp_vld[1];
  assign m0.resp_rdata = (state_q == ARB_WAIT && !grant_q) ? s.resp_rdata : '0;
  assign m1.resp_rdata = (state_q == ARB_WAIT &&  grant_q) ? s.resp_rdata : '0;

  assign s.req_valid  = s_req_vld;
  assign s.req        = req_q;
  assign s.resp_ready = s_resp_rdy;

  // A stray slave response is dropped (resp_ready stays low) but flagged.
  a_resp_only_in_wait: assert property (@(posedge clk) disable iff (!rstn)
    s.resp_valid |-> (state_q == ARB_WAIT))
    else $warning("mem_rr_arbiter: s_resp_valid outside WAIT ignored");

endmodule

// File: tb/tb_mem_rr_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_rr_arbiter: directed scenarios plus a random run, all checked against a transaction-level model.
module tb_mem_rr_arbiter;
  import mem_rr_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_rr_arbiter_if m0_if ();
  mem_rr_arbiter_if m1_if ();
  mem_rr_arbiter_if s_if ();

  mem_rr_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if)
  );

  int n_chk = 0;
  int n_err = 0;

  // transaction-level model: who owns the memory and whether the slave took the request
  int          mdl_own;
  bit          mdl_issued;
  bit          mdl_last;
  mem_req_t    mdl_req;
  logic [63:0] ref_mem [8];

  // behavioural slave
  logic [63:0] sl_mem [8];
  bit          sl_busy;
  int          sl_delay;
  logic [63:0] sl_rdata;
  bit          sl_rand;
  int          sl_stall;
  int          sl_lat;
  bit          inject;

  int          r0_cnt, r1_cnt;
  int          grant_log[$];
  logic [63:0] addr_log[$];
  bit          acc0, acc1, dut_g0, dut_g1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic mem_req_t mk_req(input logic we, input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    mem_req_t r;
    r.we = we; r.addr = a; r.wdata = d; r.wmask = m;
    return r;
  endfunction

  task automatic mdl_reset();
    mdl_own = -1; mdl_issued = 1'b0; mdl_last = 1'b1; sl_busy = 1'b0; sl_delay = 0;
  endtask

  task automatic slave_drive();
    if (sl_rand) s_if.req_ready = ($urandom_range(0, 3) != 0);
    else if (s_if.req_valid && sl_stall > 0) begin
      s_if.req_ready = 1'b0;
      sl_stall--;
    end else s_if.req_ready = 1'b1;
    if (sl_busy && sl_delay == 0) begin
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = sl_rdata;
    end else begin
      s_if.resp_valid = 1'b0;
      s_if.resp_rdata = '0;
      if (sl_busy) sl_delay--;
    end
    if (inject) begin
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = 64'h5A5A;
    end
  endtask

  // One clock: check DUT outputs against the model before the edge, then advance model and slave.
  task automatic tick();
    bit [1:0] v;
    int       win;
    bit       exp_sv, exp_wait;
    logic     own_rr;
    #1;
    v = {m1_if.req_valid, m0_if.req_valid};
    win = -1;
    if (mdl_own < 0) begin
      if (v == 2'b11) win = mdl_last ? 0 : 1;
      else if (v[0]) win = 0;
      else if (v[1]) win = 1;
    end
    exp_sv   = (mdl_own >= 0) && !mdl_issued;
    exp_wait = (mdl_own >= 0) && mdl_issued;
    own_rr   = (mdl_own == 1) ? m1_if.resp_ready : m0_if.resp_ready;
    check_eq("m0_req_ready", 256'(m0_if.req_ready), 256'(win == 0));
    check_eq("m1_req_ready", 256'(m1_if.req_ready), 256'(win == 1));
    check_eq("s_req_valid", 256'(s_if.req_valid), 256'(exp_sv));
    if (exp_sv) check_eq("s_req_payload", 256'(s_if.req), 256'(mdl_req));
    check_eq("s_resp_ready", 256'(s_if.resp_ready), 256'(exp_wait && own_rr));
    check_eq("m0_resp_valid", 256'(m0_if.resp_valid), 256'(exp_wait && mdl_own == 0 && s_if.resp_valid));
    check_eq("m1_resp_valid", 256'(m1_if.resp_valid), 256'(exp_wait && mdl_own == 1 && s_if.resp_valid));
    if (exp_wait && s_if.resp_valid && !mdl_req.we)
      check_eq(mdl_own == 1 ? "m1_resp_rdata" : "m0_resp_rdata",
               256'(mdl_own == 1 ? m1_if.resp_rdata : m0_if.resp_rdata), 256'(ref_mem[mdl_req.addr[5:3]]));

    dut_g0 = m0_if.req_ready;
    dut_g1 = m1_if.req_ready;
    if (dut_g0) grant_log.push_back(0);
    if (dut_g1) grant_log.push_back(1);
    if (m0_if.resp_valid && m0_if.resp_ready) r0_cnt++;
    if (m1_if.resp_valid && m1_if.resp_ready) r1_cnt++;
    if (s_if.resp_valid && s_if.resp_ready) sl_busy = 1'b0;
    if (s_if.req_valid && s_if.req_ready) begin
      addr_log.push_back(s_if.req.addr);
      sl_busy  = 1'b1;
      sl_delay = sl_rand ? int'($urandom_range(0, 3)) : sl_lat;
      if (s_if.req.we) begin
        sl_mem[s_if.req.addr[5:3]] = merge(sl_mem[s_if.req.addr[5:3]], s_if.req.wdata, s_if.req.wmask);
        sl_rdata = 64'hBAD0_BAD0;
      end else sl_rdata = sl_mem[s_if.req.addr[5:3]];
    end

    acc0 = (win == 0);
    acc1 = (win == 1);
    if (win >= 0) begin
      mdl_own = win; mdl_issued = 1'b0;
      mdl_req = (win == 1) ? m1_if.req : m0_if.req;
    end else if (exp_sv && s_if.req_ready) begin
      mdl_issued = 1'b1;
      if (mdl_req.we)
        ref_mem[mdl_req.addr[5:3]] = merge(ref_mem[mdl_req.addr[5:3]], mdl_req.wdata, mdl_req.wmask);
    end else if (exp_wait && s_if.resp_valid && own_rr) begin
      mdl_last = (mdl_own == 1);
      mdl_own  = -1;
    end
    @(negedge clk);
  endtask

  task automatic check_quiet(input string pfx);
    check_eq({pfx, "_m0_req_ready"}, 256'(m0_if.req_ready), 256'(0));
    check_eq({pfx, "_m1_req_ready"}, 256'(m1_if.req_ready), 256'(0));
    check_eq({pfx, "_s_req_valid"}, 256'(s_if.req_valid), 256'(0));
    check_eq({pfx, "_s_resp_ready"}, 256'(s_if.resp_ready), 256'(0));
    check_eq({pfx, "_m0_resp_valid"}, 256'(m0_if.resp_valid), 256'(0));
    check_eq({pfx, "_m1_resp_valid"}, 256'(m1_if.resp_valid), 256'(0));
    check_eq({pfx, "_s_req_payload"}, 256'(s_if.req), 256'(0));
  endtask

  // Called on a negedge; holds both masters valid through reset to show readies stay low.
  task automatic do_reset();
    rstn = 1'b0;
    m0_if.req_valid = 1'b1; m1_if.req_valid = 1'b1;
    s_if.resp_valid = 1'b0; inject = 1'b0;
    #1;
    check_quiet("rst");
    mdl_reset();
    @(negedge clk);
    m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic run_until_idle(input string tag);
    m0_if.req_valid = 1'b0; m1_if.req_valid = 1'b0;
    m0_if.resp_ready = 1'b1; m1_if.resp_ready = 1'b1;
    for (int i = 0; i < 64 && mdl_own >= 0; i++) begin
      slave_drive();
      tick();
    end
    check_eq(tag, 256'(mdl_own < 0), 256'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int       exp_g[4];
    mem_req_t exp3;
    mem_req_t q0[$], q1[$];
    int       r0_base, r1_base, wait0, wait1, max_wait;
    bit       v0, v1;

    rstn = 1'b0;
    m0_if.req_valid = 1'b0; m0_if.req = '0; m0_if.resp_ready = 1'b0;
    m1_if.req_valid = 1'b0; m1_if.req = '0; m1_if.resp_ready = 1'b0;
    s_if.req_ready = 1'b0; s_if.resp_valid = 1'b0; s_if.resp_rdata = '0;
    sl_rand = 1'b0; sl_stall = 0; sl_lat = 0; inject = 1'b0;
    r0_cnt = 0; r1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 64'h1000 + 64'(i);
      sl_mem[i]  = 64'h1000 + 64'(i);
    end
    mdl_reset();
    @(negedge clk);
    do_reset();

    // 1: lone m0 read, zero-wait slave, then back-to-back turnaround
    ref_mem[0] = 64'hDEAD; sl_mem[0] = 64'hDEAD;
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(1'b0, 64'h100, '0, '0); m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;
    slave_drive(); #1;
    check_eq("t1_c1_m0_req_ready", 256'(m0_if.req_ready), 256'(1));
    tick();
    m0_if.req_valid = 1'b0;
    slave_drive(); #1;
    check_eq("t1_c2_s_req_valid", 256'(s_if.req_valid), 256'(1));
    check_eq("t1_c2_s_req_addr", 256'(s_if.req.addr), 256'(64'h100));
    tick();
    slave_drive(); #1;
    check_eq("t1_c3_m0_resp_valid", 256'(m0_if.resp_valid), 256'(1));
    check_eq("t1_c3_m0_resp_rdata", 256'(m0_if.resp_rdata), 256'(64'hDEAD));
    check_eq("t1_c3_m1_resp_valid", 256'(m1_if.resp_valid), 256'(0));
    tick();
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(1'b0, 64'h108, '0, '0);
    slave_drive(); #1;
    check_eq("t1_c4_turnaround", 256'(m0_if.req_ready), 256'(1));
    tick();
    run_until_idle("t1_idle");

    // 2: continuous tie for four transactions
    do_reset();
    grant_log.delete(); addr_log.delete();
    sl_lat = 1;
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(1'b0, 64'h200, '0, '0);
    m1_if.req_valid = 1'b1; m1_if.req = mk_req(1'b0, 64'h318, '0, '0);
    for (int i = 0; i < 80 && grant_log.size() < 4; i++) begin
      slave_drive();
      tick();
    end
    run_until_idle("t2_idle");
    exp_g = '{0, 1, 0, 1};
    check_eq("t2_grants", 256'(grant_log.size()), 256'(4));
    check_eq("t2_issues", 256'(addr_log.size()), 256'(4));
    for (int i = 0; i < 4 && i < grant_log.size() && i < addr_log.size(); i++) begin
      check_eq("t2_grant_order", 256'(grant_log[i]), 256'(exp_g[i]));
      check_eq("t2_s_req_addr", 256'(addr_log[i]), 256'(exp_g[i] == 1 ? 64'h318 : 64'h200));
    end

    // 3: m1 write with three cycles of slave back-pressure
    sl_lat = 0; sl_stall = 3;
    exp3 = mk_req(1'b1, 64'h40, 64'h1122, 8'h0F);
    r0_base = r0_cnt; r1_base = r1_cnt;
    m1_if.req_valid = 1'b1; m1_if.req = exp3;
    slave_drive();
    tick();
    m1_if.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      slave_drive(); #1;
      check_eq("t3_s_req_valid_held", 256'(s_if.req_valid), 256'(1));
      check_eq("t3_payload_stable", 256'(s_if.req), 256'(exp3));
      tick();
    end
    run_until_idle("t3_idle");
    check_eq("t3_m1_resp_count", 256'(r1_cnt - r1_base), 256'(1));
    check_eq("t3_m0_resp_count", 256'(r0_cnt - r0_base), 256'(0));

    // 4: owner holds off its response while the other master waits
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(1'b0, 64'h80, '0, '0); m0_if.resp_ready = 1'b0;
    slave_drive();
    tick();
    m0_if.req_valid = 1'b0;
    m1_if.req_valid = 1'b1; m1_if.req = mk_req(1'b0, 64'h88, '0, '0);
    slave_drive();
    tick();
    for (int i = 0; i < 2; i++) begin
      slave_drive(); #1;
      check_eq("t4_s_resp_ready_low", 256'(s_if.resp_ready), 256'(0));
      check_eq("t4_still_wait", 256'(m0_if.resp_valid), 256'(1));
      check_eq("t4_m1_req_ready_low", 256'(m1_if.req_ready), 256'(0));
      tick();
    end
    m0_if.resp_ready = 1'b1;
    slave_drive();
    tick();
    slave_drive(); #1;
    check_eq("t4_m1_granted_after", 256'(m1_if.req_ready), 256'(1));
    tick();
    run_until_idle("t4_idle");

    // 5: reset while a read is waiting for the owner to accept its response
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(1'b0, 64'h90, '0, '0); m0_if.resp_ready = 1'b0;
    slave_drive(); tick();
    m0_if.req_valid = 1'b0;
    slave_drive(); tick();
    slave_drive(); #2;
    rstn = 1'b0;
    m0_if.req_valid = 1'b1; m1_if.req_valid = 1'b1;
    #1;
    check_quiet("t5");
    mdl_reset();
    @(negedge clk);
    rstn = 1'b1;
    m0_if.resp_ready = 1'b1;
    m0_if.req = mk_req(1'b0, 64'h98, '0, '0);
    m1_if.req = mk_req(1'b0, 64'hA0, '0, '0);
    slave_drive(); #1;
    check_eq("t5_m0_wins_tie", 256'(m0_if.req_ready), 256'(1));
    check_eq("t5_m1_loses_tie", 256'(m1_if.req_ready), 256'(0));
    tick();
    run_until_idle("t5_idle");

    // 6: stray slave response while idle
    inject = 1'b1;
    slave_drive(); #1;
    check_eq("t6_s_resp_ready", 256'(s_if.resp_ready), 256'(0));
    check_eq("t6_m0_resp_valid", 256'(m0_if.resp_valid), 256'(0));
    check_eq("t6_m1_resp_valid", 256'(m1_if.resp_valid), 256'(0));
    tick();
    inject = 1'b0;

    // random traffic
    sl_rand = 1'b1;
    for (int i = 0; i < 25; i++) begin
      q0.push_back(mk_req(1'($urandom_range(0, 1)), (64'($urandom_range(0, 255)) << 6) | (64'($urandom_range(0, 7)) << 3),
                          {$urandom, $urandom}, 8'($urandom_range(0, 255))));
      q1.push_back(mk_req(1'($urandom_range(0, 1)), (64'($urandom_range(0, 255)) << 6) | (64'($urandom_range(0, 7)) << 3),
                          {$urandom, $urandom}, 8'($urandom_range(0, 255))));
    end
    r0_base = r0_cnt; r1_base = r1_cnt;
    wait0 = 0; wait1 = 0; max_wait = 0;
    for (int cyc = 0; cyc < 3000 && (q0.size() > 0 || q1.size() > 0 || mdl_own >= 0); cyc++) begin
      v0 = (q0.size() > 0) && ($urandom_range(0, 3) != 0);
      v1 = (q1.size() > 0) && ($urandom_range(0, 3) != 0);
      m0_if.req_valid = v0; if (q0.size() > 0) m0_if.req = q0[0];
      m1_if.req_valid = v1; if (q1.size() > 0) m1_if.req = q1[0];
      m0_if.resp_ready = ($urandom_range(0, 3) != 0);
      m1_if.resp_ready = ($urandom_range(0, 3) != 0);
      slave_drive();
      tick();
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      if (v0 && !dut_g0) begin if (dut_g1) wait0++; end else wait0 = 0;
      if (v1 && !dut_g1) begin if (dut_g0) wait1++; end else wait1 = 0;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait1 > max_wait) max_wait = wait1;
    end
    check_eq("rand_m0_done", 256'(r0_cnt - r0_base), 256'(25));
    check_eq("rand_m1_done", 256'(r1_cnt - r1_base), 256'(25));
    check_eq("rand_fairness", 256'(max_wait <= 1), 256'(1));
    run_until_idle("rand_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
